// File: rtl/f_adder_pkg.sv
// Shared types and constants for the single-precision adder result stage.
// Operand classes, result flags, the in-flight tag and the FIFO entry layout
// live here so the top and the result FIFO agree on widths.
package f_adder_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam int          RES_W   = 35;

    typedef enum logic [1:0] {
        FIN = 2'd0,
        INF = 2'd1,
        NAN = 2'd2
    } op_class_e;

    // Flag bit order on the output bus is {NV, OF, ZR}.
    typedef struct packed {
        logic nv;
        logic of;
        logic zr;
    } flags_t;

    // Per-operation record carried alongside the adder latency.
    typedef struct packed {
        logic      valid;
        op_class_e aclass;
        logic      asign;
        op_class_e bclass;
        logic      bsign;
    } tag_t;

    // FIFO entry: flags in the top three bits, IEEE-754 word below.
    typedef struct packed {
        flags_t      flags;
        logic [31:0] sum;
    } result_t;

    // Operand classification from the raw IEEE-754 bit pattern.
    function automatic op_class_e classify(input logic [31:0] x);
        if (x[30:23] != EXP_MAX) begin
            return FIN;
        end else if (x[22:0] != 23'd0) begin
            return NAN;
        end else begin
            return INF;
        end
    endfunction

endpackage

// File: rtl/f_adder_resfifo.sv
// Show-ahead result FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable; the head word reads as zero while the FIFO is empty.
// Storage is deliberately not reset: only the pointers define occupancy.
module f_adder_resfifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_wr;
    logic             do_rd;

    // Occupancy decode, guarded pointer advance and show-ahead head read.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/f_adder_outstage.sv
// Result-side companion to the pipelined single-precision adder.
// A LAT-deep tag pipeline marks which adder cycles carry real operations,
// IEEE-754 special cases are patched onto the raw sum, and results are queued
// in a show-ahead FIFO. A credit counter throttles issue so that results
// already in the non-stallable adder always find a FIFO slot.
// Optional feature macro: F_ADDER_STATS_EN adds saturating NV/OF counters.
module f_adder_outstage
    import f_adder_pkg::*;
#(
    parameter int LAT   = 6,
    parameter int DEPTH = 8
) (
    input  logic        clk18,
    input  logic        rst_n18,
    input  logic        in_valid18,
    output logic        in_ready18,
    input  logic [31:0] a_original18,
    input  logic [31:0] b_original18,
    input  logic [31:0] sum18,
    output logic        out_valid18,
    input  logic        out_ready18,
    output logic [31:0] out_sum18,
    output logic [2:0]  out_flags18
`ifdef F_ADDER_STATS_EN
    ,
    output logic [15:0] cnt_nv18,
    output logic [15:0] cnt_of18
`endif
);

    localparam int             RW      = $clog2(DEPTH) + 1;
    localparam logic [RW-1:0]  ONE     = RW'(1);
    localparam logic [RW-1:0]  DEPTH_C = RW'(DEPTH);

    logic [RW-1:0] reserved_q, reserved_d;
    tag_t          tag_q [LAT];
    tag_t          tag_d [LAT];
    tag_t          tag_new;
    tag_t          tag_out;
    result_t       res_w;
    result_t       head;
    logic          accept;
    logic          pop;
    logic          fifo_empty;

    // Special-case overrides in priority order; the raw sum passes through
    // only for finite operands without exponent overflow.
    function automatic result_t form_result(input tag_t t, input logic [31:0] s);
        result_t r;
        r.flags = '0;
        r.sum   = s;
        if (t.aclass == NAN || t.bclass == NAN) begin
            r.sum      = QNAN;
            r.flags.nv = 1'b1;
        end else if (t.aclass == INF && t.bclass == INF && t.asign != t.bsign) begin
            r.sum      = QNAN;
            r.flags.nv = 1'b1;
        end else if (t.aclass == INF) begin
            r.sum = {t.asign, EXP_MAX, 23'd0};
        end else if (t.bclass == INF) begin
            r.sum = {t.bsign, EXP_MAX, 23'd0};
        end else if (s[30:23] == EXP_MAX) begin
            r.sum      = {s[31], EXP_MAX, 23'd0};
            r.flags.of = 1'b1;
        end else begin
            r.flags.zr = (s[30:0] == 31'd0);
        end
        return r;
    endfunction

    // Saturating event counter increment.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Issue handshake, credit accounting and the tag entering the pipeline.
    always_comb begin
        in_ready18     = (reserved_q < DEPTH_C);
        accept         = in_valid18 && in_ready18;
        pop            = out_valid18 && out_ready18;
        reserved_d     = reserved_q;
        if (accept && !pop) begin
            reserved_d = reserved_q + ONE;
        end else if (pop && !accept) begin
            reserved_d = reserved_q - ONE;
        end
        tag_new        = '0;
        tag_new.valid  = accept;
        tag_new.aclass = classify(a_original18);
        tag_new.asign  = a_original18[31];
        tag_new.bclass = classify(b_original18);
        tag_new.bsign  = b_original18[31];
    end

    // Tag shift: stage 0 is the newest, stage LAT-1 lines up with sum18.
    always_comb begin
        tag_d[0] = tag_new;
        for (int i = 1; i < LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        tag_out = tag_q[LAT-1];
        res_w   = form_result(tag_out, sum18);
    end

    // Credit counter and tag pipeline; reset discards everything in flight.
    always_ff @(posedge clk18 or negedge rst_n18) begin
        if (!rst_n18) begin
            reserved_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            reserved_q <= reserved_d;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    f_adder_resfifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W)
    ) u_resfifo (
        .clk     (clk18),
        .rst_n   (rst_n18),
        .wr_en   (tag_out.valid),
        .wr_data (res_w),
        .rd_en   (out_ready18),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    // Output view of the FIFO head (zero while empty).
    always_comb begin
        out_valid18 = !fifo_empty;
        out_sum18   = head.sum;
        out_flags18 = head.flags;
    end

`ifdef F_ADDER_STATS_EN
    logic [15:0] cnt_nv_q, cnt_nv_d;
    logic [15:0] cnt_of_q, cnt_of_d;

    // Count results written with invalid or overflow flags.
    always_comb begin
        cnt_nv_d = cnt_nv_q;
        cnt_of_d = cnt_of_q;
        if (tag_out.valid && res_w.flags.nv) begin
            cnt_nv_d = sat_inc(cnt_nv_q);
        end
        if (tag_out.valid && res_w.flags.of) begin
            cnt_of_d = sat_inc(cnt_of_q);
        end
        cnt_nv18 = cnt_nv_q;
        cnt_of18 = cnt_of_q;
    end

    // Statistics registers.
    always_ff @(posedge clk18 or negedge rst_n18) begin
        if (!rst_n18) begin
            cnt_nv_q <= '0;
            cnt_of_q <= '0;
        end else begin
            cnt_nv_q <= cnt_nv_d;
            cnt_of_q <= cnt_of_d;
        end
    end
`endif

endmodule
